// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with skid buffer and branch redirect
module instr_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [63:0] instr_pc,
  output logic [6:0]  opcode_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  funct7_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic        drop_resp, drop_resp_n;
  logic        instr_valid_n;
  logic [31:0] instr_out_n;
  logic [63:0] instr_pc_n;
  logic [31:0] skid_data, skid_data_n;
  logic [63:0] skid_pc, skid_pc_n;
  logic [63:0] target_aligned;
  logic        out_free;

  assign target_aligned = branch_target & ~64'h3;
  // The output register can take new data if empty or being consumed this cycle.
  assign out_free       = !instr_valid || !stall;

  assign imem_addr  = pc;
  assign opcode_out = instr_out[6:0];
  assign funct3_out = instr_out[14:12];
  assign funct7_out = instr_out[31:25];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    pc_n           = pc;
    drop_resp_n    = drop_resp;
    instr_valid_n  = instr_valid;
    instr_out_n    = instr_out;
    instr_pc_n     = instr_pc;
    skid_data_n    = skid_data;
    skid_pc_n      = skid_pc;
    imem_req_valid = 1'b0;

    if (instr_valid && !stall) begin
      instr_valid_n = 1'b0;
    end

    case (state)
      S_REQ: begin
        imem_req_valid = 1'b1;
        if (imem_req_ready) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_resp) begin
            drop_resp_n = 1'b0;
            state_n     = S_REQ;
          end else if (out_free) begin
            instr_out_n   = imem_resp_data;
            instr_pc_n    = pc;
            instr_valid_n = 1'b1;
            pc_n          = pc + 64'd4;
            state_n       = S_REQ;
          end else begin
            skid_data_n = imem_resp_data;
            skid_pc_n   = pc;
            pc_n        = pc + 64'd4;
            state_n     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          instr_out_n   = skid_data;
          instr_pc_n    = skid_pc;
          instr_valid_n = 1'b1;
          state_n       = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase

    // Redirect overrides everything; an accepted-but-unanswered request must have its response dropped.
    if (branch_taken) begin
      pc_n          = target_aligned;
      instr_valid_n = 1'b0;
      instr_out_n   = 32'h0;
      instr_pc_n    = 64'h0;
      skid_data_n   = 32'h0;
      skid_pc_n     = 64'h0;
      case (state)
        S_REQ: begin
          state_n     = imem_req_ready ? S_WAIT : S_REQ;
          drop_resp_n = imem_req_ready;
        end
        S_WAIT: begin
          state_n     = imem_resp_valid ? S_REQ : S_WAIT;
          drop_resp_n = !imem_resp_valid;
        end
        default: begin
          state_n     = S_REQ;
          drop_resp_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      drop_resp   <= 1'b0;
      instr_valid <= 1'b0;
      instr_out   <= 32'h0;
      instr_pc    <= 64'h0;
      skid_data   <= 32'h0;
      skid_pc     <= 64'h0;
    end else begin
      pc          <= pc_n;
      drop_resp   <= drop_resp_n;
      instr_valid <= instr_valid_n;
      instr_out   <= instr_out_n;
      instr_pc    <= instr_pc_n;
      skid_data   <= skid_data_n;
      skid_pc     <= skid_pc_n;
    end
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: RESET_PC, 64'h0, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 imem_req_valid  output  1  fetch request valid.
REQ-005 imem_req_ready  input  1  memory accepts request.
REQ-006 imem_addr  output  64  fetch address (PC).
REQ-007 imem_resp_valid  input  1  response data valid; at most one outstanding request.
REQ-008 imem_resp_data  input  32  fetched instruction word.
REQ-009 branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-010 branch_target  input  64  redirect address.
REQ-011 stall  input  1  decode cannot accept; holds output.
REQ-012 instr_valid  output  1  instr_out holds a valid instruction.
REQ-013 instr_out  output  32  registered instruction word.
REQ-014 instr_pc  output  64  PC of instr_out.
REQ-015 opcode_out / funct3_out / funct7_out  output  7/3/7  instr_out[6:0], [14:12], [31:25], combinational from the output register.

Function
REQ-016 The FSM SHALL have states REQ, WAIT, HOLD.
REQ-017 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready -> WAIT; else stay REQ.
REQ-018 WAIT: imem_req_valid=0; on imem_resp_valid with no drop pending: if output empty or consumed this cycle (!instr_valid || !stall) load output register (instr_out=data, instr_pc=pc, instr_valid=1), pc<=pc+4, -> REQ; else write skid buffer (data, pc), pc<=pc+4, -> HOLD.
REQ-019 HOLD: imem_req_valid=0; when stall=0 skid moves into output register in the same edge, instr_valid stays 1, -> REQ.
REQ-020 Consumption: output is consumed on any cycle with instr_valid=1 and stall=0; if not reloaded that edge, instr_valid<=0.
REQ-021 Output register and skid SHALL hold value unchanged while stall=1.
REQ-022 pc+4 SHALL wrap modulo 2^64; branch_target[1:0] SHALL be forced to 2'b00 when loaded.
REQ-023 branch_taken (priority over stall and all other events): pc<=target, instr_valid<=0, skid discarded, next state REQ from REQ/HOLD.
REQ-024 branch_taken in WAIT, or in REQ in the same cycle as imem_req_ready: drop_resp<=1, state WAIT; the next response SHALL be discarded (no output load, no pc increment), drop_resp<=0, -> REQ.
REQ-025 branch_taken in REQ without handshake: request address changes to target next cycle; no response expected.
REQ-026 Fetch-to-output latency: one cycle after imem_resp_valid (registered output).
REQ-027 Never more than one request outstanding; imem_req_valid SHALL be 0 in WAIT and HOLD.

Reset
REQ-028 rst=1 at a clock edge: pc=RESET_PC, state=REQ, instr_valid=0, instr_out=0, instr_pc=0, skid cleared, drop_resp=0; overrides branch_taken and any in-flight response.
REQ-029 First cycle after rst deasserts: imem_req_valid=1, imem_addr=RESET_PC.
REQ-030 Responses arriving after a reset that interrupted WAIT SHALL be ignored unless a request has been issued since reset.

Verification
REQ-031 Reset, ready=1, response 1 cycle after each accept, data 0x00A00093/0x00B00113 -> instr_out sequence with instr_pc 0x0, 0x4; instr_valid pulses each response.
REQ-032 stall=1 while output valid (pc 0x4), response 0x002081B3 arrives -> HOLD, instr_out unchanged, no request; stall=0 -> instr_out=0x002081B3, instr_pc=0x8, request addr 0xC next cycle.
REQ-033 branch_taken target 0x103 while in WAIT -> response discarded, instr_valid=0, next request addr 0x100.
REQ-034 branch_taken with stall=1 in HOLD -> skid and output cleared, request addr=target next cycle.
REQ-035 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, one fetch -> next imem_addr 0x0.
REQ-036 rst asserted in WAIT, response arrives same cycle -> all outputs at reset values, next request addr RESET_PC.
